// File: rtl/n64_pi_responder_pkg.sv
// rtl/n64_pi_responder_pkg.sv - bank codes, responder state encoding and half-word select helper
package n64_pi_responder_pkg;

  localparam logic [3:0] BANK_ROM     = 4'd0;
  localparam logic [3:0] BANK_SRAM    = 4'd1;
  localparam logic [3:0] BANK_INVALID = 4'hF;

  typedef enum logic [2:0] {
    N64_PI_STATE_IDLE,
    N64_PI_STATE_ADDR,
    N64_PI_STATE_FETCH,
    N64_PI_STATE_READY,
    N64_PI_STATE_WCOLLECT,
    N64_PI_STATE_WISSUE
  } n64_pi_state_e;

  // The N64 is big-endian: the even half-word is the upper 16 bits of the word.
  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic odd);
    return odd ? word[15:0] : word[31:16];
  endfunction

endpackage

// File: rtl/n64_pi_sync.sv
// rtl/n64_pi_sync.sv - multi-flop synchronizer for one PI strobe with rise/fall pulses
module n64_pi_sync #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/n64_pi_responder.sv
// rtl/n64_pi_responder.sv - N64 PI bus responder turning half-word cycles into 32-bit bank requests
// Optional read-ahead into a second word slot: define N64_PI_PREFETCH_EN.
module n64_pi_responder
  import n64_pi_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_n64_pi_aleh,
  input  logic        i_n64_pi_alel,
  input  logic        i_n64_pi_read,
  input  logic        i_n64_pi_write,
  input  logic [15:0] i_n64_pi_ad,
  output logic [15:0] o_n64_pi_ad,
  output logic        o_n64_pi_ad_oe,
  output logic [31:0] o_address,
  input  logic [3:0]  i_bank,
  input  logic        i_bank_prefetch,
  output logic        o_request,
  output logic        o_write,
  output logic [31:0] o_data,
  input  logic        i_ack,
  input  logic [31:0] i_data
);

`ifdef N64_PI_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  logic aleh_s, aleh_rise, aleh_fall;
  logic alel_s, alel_rise, alel_fall;
  logic read_s, read_rise, read_fall;
  logic write_s, write_rise, write_fall;
  logic unused_edges;

  n64_pi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_aleh (
    .clk(i_clk), .reset(i_reset), .d(i_n64_pi_aleh), .q(aleh_s), .rise(aleh_rise), .fall(aleh_fall));
  n64_pi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_alel (
    .clk(i_clk), .reset(i_reset), .d(i_n64_pi_alel), .q(alel_s), .rise(alel_rise), .fall(alel_fall));
  n64_pi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_read (
    .clk(i_clk), .reset(i_reset), .d(i_n64_pi_read), .q(read_s), .rise(read_rise), .fall(read_fall));
  n64_pi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_write (
    .clk(i_clk), .reset(i_reset), .d(i_n64_pi_write), .q(write_s), .rise(write_rise), .fall(write_fall));

  assign unused_edges = ^{aleh_s, alel_s, alel_rise, write_s, write_fall};

  logic [15:0] ad_chain [SYNC_STAGES];
  logic [15:0] ad_s;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) ad_chain[i] <= '0;
    end else begin
      ad_chain[0] <= i_n64_pi_ad;
      for (int i = 1; i < SYNC_STAGES; i++) ad_chain[i] <= ad_chain[i-1];
    end
  end

  assign ad_s = ad_chain[SYNC_STAGES-1];

  n64_pi_state_e state, nxt;
  logic [31:0] address, buf_data, pf_data;
  logic [15:0] hold_data, ad_out;
  logic        buf_valid, pf_valid, pf_busy, discard, hold_valid, oe;
  logic        bank_ok, own_ack, wr_edge, has_next, pf_issue;
  logic [15:0] next_half;

  assign bank_ok   = (i_bank != BANK_INVALID);
  // An ack belongs to the FSM only if it answers its own, still-wanted request.
  assign own_ack   = o_request & i_ack & ~discard & ~pf_busy;
  // Write edges while READ is low are a protocol error; the read wins.
  assign wr_edge   = write_rise & read_s;
  assign has_next  = hold_valid | wr_edge;
  assign next_half = hold_valid ? hold_data : ad_s;
  assign pf_issue  = PF_EN && (state == N64_PI_STATE_READY) && buf_valid && !pf_valid && !o_request
                     && i_bank_prefetch && bank_ok && !aleh_rise && !read_rise && !wr_edge;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= N64_PI_STATE_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (aleh_rise) begin
      nxt = N64_PI_STATE_ADDR;
    end else begin
      case (state)
        N64_PI_STATE_ADDR:     if (alel_fall) nxt = N64_PI_STATE_READY;
        N64_PI_STATE_READY,
        N64_PI_STATE_WCOLLECT: begin
          if (read_fall)
            nxt = (bank_ok && !buf_valid) ? N64_PI_STATE_FETCH : N64_PI_STATE_READY;
          else if (wr_edge && bank_ok)
            nxt = address[1] ? N64_PI_STATE_WISSUE : N64_PI_STATE_WCOLLECT;
        end
        N64_PI_STATE_FETCH:    if (own_ack) nxt = N64_PI_STATE_READY;
        N64_PI_STATE_WISSUE:   if (own_ack) nxt = has_next ? N64_PI_STATE_WCOLLECT : N64_PI_STATE_READY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      address    <= '0;
      buf_data   <= '0;
      pf_data    <= '0;
      hold_data  <= '0;
      ad_out     <= '0;
      buf_valid  <= 1'b0;
      pf_valid   <= 1'b0;
      pf_busy    <= 1'b0;
      discard    <= 1'b0;
      hold_valid <= 1'b0;
      oe         <= 1'b0;
      o_request  <= 1'b0;
      o_write    <= 1'b0;
      o_data     <= '0;
    end else begin
      if (o_request && i_ack) begin
        o_request <= 1'b0;
        discard   <= 1'b0;
        pf_busy   <= 1'b0;
        if (pf_busy && !discard) begin
          pf_data  <= i_data;
          pf_valid <= 1'b1;
        end
      end else if (!o_request && !aleh_rise &&
                   (state == N64_PI_STATE_FETCH || state == N64_PI_STATE_WISSUE)) begin
        o_request <= 1'b1;
        o_write   <= (state == N64_PI_STATE_WISSUE);
      end else if (pf_issue) begin
        o_request <= 1'b1;
        o_write   <= 1'b0;
        pf_busy   <= 1'b1;
      end

      if (aleh_rise) begin
        buf_valid  <= 1'b0;
        pf_valid   <= 1'b0;
        hold_valid <= 1'b0;
        oe         <= 1'b0;
        if (o_request && !i_ack) discard <= 1'b1;
      end else begin
        case (state)
          N64_PI_STATE_ADDR: begin
            if (aleh_fall) address[31:16] <= ad_s;
            if (alel_fall) address[15:0]  <= {ad_s[15:1], 1'b0};
          end
          N64_PI_STATE_READY,
          N64_PI_STATE_WCOLLECT: begin
            if (read_fall) begin
              if (!bank_ok) begin
                ad_out <= '0;
                oe     <= 1'b1;
              end else if (buf_valid) begin
                ad_out <= pick_half(buf_data, address[1]);
                oe     <= 1'b1;
              end
            end else if (read_rise) begin
              oe      <= 1'b0;
              address <= address + 32'd2;
              if (address[1]) begin
                buf_data  <= pf_data;
                buf_valid <= pf_valid;
                pf_valid  <= 1'b0;
                if (pf_busy && !i_ack) discard <= 1'b1;
              end
            end else if (wr_edge) begin
              buf_valid <= 1'b0;
              pf_valid  <= 1'b0;
              if (pf_busy && !i_ack) discard <= 1'b1;
              // The odd half stays on its word address until the write is acked.
              if (bank_ok && address[1]) begin
                o_data[15:0] <= ad_s;
              end else begin
                address <= address + 32'd2;
                if (bank_ok) o_data[31:16] <= ad_s;
              end
            end
          end
          N64_PI_STATE_FETCH: begin
            if (own_ack) begin
              buf_data  <= i_data;
              buf_valid <= 1'b1;
              ad_out    <= pick_half(i_data, address[1]);
              oe        <= 1'b1;
            end
          end
          N64_PI_STATE_WISSUE: begin
            if (own_ack) begin
              hold_valid <= 1'b0;
              if (has_next) begin
                o_data[31:16] <= next_half;
                address       <= address + 32'd4;
              end else begin
                address <= address + 32'd2;
              end
            end else if (wr_edge && !hold_valid) begin
              hold_data  <= ad_s;
              hold_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_n64_pi_ad    = ad_out;
    o_n64_pi_ad_oe = oe;
    o_address      = {address[31:2], 2'b00} + ((pf_busy && !discard) ? 32'd4 : 32'd0);
  end

endmodule

// File: tb/tb_n64_pi_responder.sv
// tb/tb_n64_pi_responder.sv - self-checking bench for n64_pi_responder with a word-memory bank model
module tb_n64_pi_responder;
  import n64_pi_responder_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_n64_pi_aleh = 1'b0, i_n64_pi_alel = 1'b0;
  logic        i_n64_pi_read = 1'b1, i_n64_pi_write = 1'b1;
  logic [15:0] i_n64_pi_ad = '0;
  logic [15:0] o_n64_pi_ad;
  logic        o_n64_pi_ad_oe;
  logic [31:0] o_address;
  logic [3:0]  i_bank = BANK_ROM;
  logic        i_bank_prefetch = 1'b0;
  logic        o_request, o_write;
  logic [31:0] o_data;
  logic        i_ack = 1'b0;
  logic [31:0] i_data = '0;

  n64_pi_responder #(.SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_n64_pi_aleh(i_n64_pi_aleh), .i_n64_pi_alel(i_n64_pi_alel),
    .i_n64_pi_read(i_n64_pi_read), .i_n64_pi_write(i_n64_pi_write),
    .i_n64_pi_ad(i_n64_pi_ad), .o_n64_pi_ad(o_n64_pi_ad), .o_n64_pi_ad_oe(o_n64_pi_ad_oe),
    .o_address(o_address), .i_bank(i_bank), .i_bank_prefetch(i_bank_prefetch),
    .o_request(o_request), .o_write(o_write), .o_data(o_data),
    .i_ack(i_ack), .i_data(i_data));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    int          falls;
  } req_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem [logic [31:0]];
  req_t        req_q [$];
  bit          auto_ack = 1'b1;
  int          req_cycles = 0;
  int          read_falls = 0;

  function automatic logic [3:0] bank_of(input logic [31:0] a);
    if (a[31:24] == 8'h05) return BANK_INVALID;
    if (a[31:24] == 8'h08) return BANK_SRAM;
    return BANK_ROM;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  function automatic logic [15:0] exp_half(input logic [31:0] a);
    logic [31:0] w;
    if (bank_of(a) == BANK_INVALID) return 16'h0000;
    w = word_at(a);
    return a[1] ? w[15:0] : w[31:16];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bank model: decodes o_address every cycle and answers requests after a random delay.
  initial begin
    int dly;
    dly = 0;
    forever begin
      @(negedge clk);
      i_bank = bank_of(o_address);
      if (o_request) req_cycles++;
      if (auto_ack) begin
        i_ack = 1'b0;
        if (o_request) begin
          if (dly == 0) begin
            req_q.push_back('{addr: o_address, wr: o_write, data: o_write ? o_data : 32'h0, falls: read_falls});
            if (o_write) mem[o_address] = o_data;
            else         i_data = word_at(o_address);
            i_ack = 1'b1;
            dly = $urandom_range(0, 3);
          end else begin
            dly--;
          end
        end
      end
    end
  end

  task automatic set_addr(input logic [31:0] a);
    i_n64_pi_ad   = a[31:16];
    i_n64_pi_alel = 1'b1;
    i_n64_pi_aleh = 1'b1;
    cycles(4);
    i_n64_pi_aleh = 1'b0;
    cycles(4);
    i_n64_pi_ad = a[15:0];
    cycles(2);
    i_n64_pi_alel = 1'b0;
    cycles(4);
  endtask

  task automatic pi_read(output logic [15:0] v, output logic ok, output int lat);
    read_falls++;
    i_n64_pi_read = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_n64_pi_ad_oe && lat < 200);
    ok = o_n64_pi_ad_oe;
    v  = o_n64_pi_ad;
    i_n64_pi_read = 1'b1;
    cycles(5);
  endtask

  task automatic pi_write(input logic [15:0] v);
    i_n64_pi_ad = v;
    cycles(2);
    i_n64_pi_write = 1'b0;
    cycles(4);
    i_n64_pi_write = 1'b1;
    cycles(5);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [15:0] exp);
    logic [15:0] v;
    logic        ok;
    int          lat;
    pi_read(v, ok, lat);
    chk($sformatf("%s oe", tag), {31'd0, ok}, 32'd1);
    chk(tag, {16'd0, v}, {16'd0, exp});
  endtask

  task automatic wait_req(input int limit);
    int n;
    n = 0;
    while (!o_request && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [15:0] h0, h1, v;
    logic        ok;
    int          nr, nw, lat, n;

    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [15:0] h0, h1, v;
    logic        ok;
    int          nr, nw, lat, n;

    mem[32'h1000_0040] = 32'h1122_3344;
    mem[32'h1000_0044] = 32'h5566_7788;

    cycles(3);
    chk("reset o_request", {31'd0, o_request}, 32'd0);
    chk("reset oe", {31'd0, o_n64_pi_ad_oe}, 32'd0);
    chk("reset ad", {16'd0, o_n64_pi_ad}, 32'd0);
    chk("reset o_address", o_address, 32'd0);
    chk("reset o_data", o_data, 32'd0);
    chk("reset o_write", {31'd0, o_write}, 32'd0);
    i_reset = 1'b0;
    cycles(3);

    // ROM read without prefetch
    req_q.delete();
    set_addr(32'h1000_0040);
    read_chk("rom read0", 32'h1000_0040, 16'h1122);
    read_chk("rom read1", 32'h1000_0042, 16'h3344);
    read_chk("rom read2", 32'h1000_0044, 16'h5566);
    read_chk("rom read3", 32'h1000_0046, 16'h7788);
    chk("rom req count", req_q.size(), 32'd2);
    if (req_q.size() == 2) begin
      chk("rom req0 addr", req_q[0].addr, 32'h1000_0040);
      chk("rom req1 addr", req_q[1].addr, 32'h1000_0044);
      chk("rom req0 dir", {31'd0, req_q[0].wr}, 32'd0);
    end

    // SRAM write
    req_q.delete();
    set_addr(32'h0800_0000);
    pi_write(16'hAAAA);
    pi_write(16'hBBBB);
    n = 0;
    while (req_q.size() == 0 && n < 40) begin cycles(1); n++; end
    cycles(5);
    chk("sram wr count", req_q.size(), 32'd1);
    if (req_q.size() >= 1) begin
      chk("sram wr dir", {31'd0, req_q[0].wr}, 32'd1);
      chk("sram wr addr", req_q[0].addr, 32'h0800_0000);
      chk("sram wr data", req_q[0].data, 32'hAAAA_BBBB);
    end

    // Invalid bank
    set_addr(32'h0500_0000);
    req_cycles = 0;
    read_chk("invalid read0", 32'h0500_0000, 16'h0000);
    read_chk("invalid read1", 32'h0500_0002, 16'h0000);
    chk("invalid no request", req_cycles, 32'd0);

    // Address wrap across the top of the 32-bit space
    req_q.delete();
    set_addr(32'hFFFF_FFFE);
    read_chk("wrap read0", 32'hFFFF_FFFE, exp_half(32'hFFFF_FFFE));
    read_chk("wrap read1", 32'h0000_0000, exp_half(32'h0000_0000));
    chk("wrap req count", req_q.size(), 32'd2);
    if (req_q.size() == 2) begin
      chk("wrap req0 addr", req_q[0].addr, 32'hFFFF_FFFC);
      chk("wrap req1 addr", req_q[1].addr, 32'h0000_0000);
    end

    // Randomised ROM reads against the word-memory model
    for (int it = 0; it < 4; it++) begin
      a  = 32'h1000_0000 | ($urandom & 32'h00FF_FFFC) | ($urandom_range(0, 1) << 1);
      nr = $urandom_range(1, 6);
      req_q.delete();
      set_addr(a);
      for (int k = 0; k < nr; k++) begin
        pi_read(v, ok, lat);
        chk($sformatf("rnd%0d read%0d oe", it, k), {31'd0, ok}, 32'd1);
        chk($sformatf("rnd%0d read%0d @%h", it, k, a + 2 * k), {16'd0, v}, {16'd0, exp_half(a + 2 * k)});
      end
      nw = ((a + 2 * (nr - 1)) >> 2) - (a >> 2) + 1;
      chk($sformatf("rnd%0d req count", it), req_q.size(), nw);
      foreach (req_q[j])
        chk($sformatf("rnd%0d req%0d addr", it, j), req_q[j].addr, {a[31:2], 2'b00} + 4 * j);
    end

    // Randomised SRAM write then read-back
    for (int it = 0; it < 3; it++) begin
      a  = 32'h0800_0000 | ($urandom & 32'h0000_FFFC);
      h0 = $urandom;
      h1 = $urandom;
      req_q.delete();
      set_addr(a);
      pi_write(h0);
      pi_write(h1);
      n = 0;
      while (req_q.size() == 0 && n < 40) begin cycles(1); n++; end
      cycles(3);
      chk($sformatf("wr%0d count", it), req_q.size(), 32'd1);
      if (req_q.size() >= 1) begin
        chk($sformatf("wr%0d addr", it), req_q[0].addr, a);
        chk($sformatf("wr%0d data", it), req_q[0].data, {h0, h1});
      end
      set_addr(a);
      read_chk($sformatf("wr%0d readback hi", it), a, h0);
      read_chk($sformatf("wr%0d readback lo", it), a + 2, h1);
    end

    // Abort while a fetch waits for its ack
    auto_ack = 1'b0;
    cycles(2);
    set_addr(32'h1000_0200);
    i_n64_pi_read = 1'b0;
    wait_req(50);
    chk("abort first req", {31'd0, o_request}, 32'd1);
    chk("abort first addr", o_address, 32'h1000_0200);
    i_n64_pi_read = 1'b1;
    cycles(5);
    set_addr(32'h1000_0100);
    i_n64_pi_read = 1'b0;
    cycles(8);
    chk("abort old req held", {31'd0, o_request}, 32'd1);
    chk("abort no stale oe", {31'd0, o_n64_pi_ad_oe}, 32'd0);
    i_data = 32'hDEAD_BEEF;
    i_ack  = 1'b1;
    cycles(1);
    i_ack  = 1'b0;
    chk("abort req drops", {31'd0, o_request}, 32'd0);
    chk("abort stale not driven", {31'd0, o_n64_pi_ad_oe}, 32'd0);
    wait_req(20);
    chk("abort new req", {31'd0, o_request}, 32'd1);
    chk("abort new addr", o_address, 32'h1000_0100);
    i_data = word_at(32'h1000_0100);
    i_ack  = 1'b1;
    cycles(1);
    i_ack  = 1'b0;
    chk("abort new oe", {31'd0, o_n64_pi_ad_oe}, 32'd1);
    chk("abort new data", {16'd0, o_n64_pi_ad}, {16'd0, exp_half(32'h1000_0100)});
    i_n64_pi_read = 1'b1;
    cycles(5);

    // Reset while a write request is outstanding
    set_addr(32'h0800_0010);
    pi_write(16'h1234);
    pi_write(16'h5678);
    wait_req(30);
    chk("wissue req", {31'd0, o_request}, 32'd1);
    chk("wissue dir", {31'd0, o_write}, 32'd1);
    i_reset = 1'b1;
    cycles(1);
    chk("mid reset o_request", {31'd0, o_request}, 32'd0);
    chk("mid reset oe", {31'd0, o_n64_pi_ad_oe}, 32'd0);
    chk("mid reset ad", {16'd0, o_n64_pi_ad}, 32'd0);
    chk("mid reset o_address", o_address, 32'd0);
    chk("mid reset o_data", o_data, 32'd0);
    chk("mid reset o_write", {31'd0, o_write}, 32'd0);
    i_reset  = 1'b0;
    auto_ack = 1'b1;
    cycles(4);

`ifdef N64_PI_PREFETCH_EN
    i_bank_prefetch = 1'b1;
    req_q.delete();
    read_falls = 0;
    set_addr(32'h1000_0000);
    for (int k = 0; k < 8; k++) begin
      pi_read(v, ok, lat);
      chk($sformatf("pf read%0d oe", k), {31'd0, ok}, 32'd1);
      chk($sformatf("pf read%0d", k), {16'd0, v}, {16'd0, exp_half(32'h1000_0000 + 2 * k)});
      if (k >= 2) chk($sformatf("pf read%0d no stall", k), {31'd0, lat <= 4}, 32'd1);
    end
    n = -1;
    foreach (req_q[j]) if (n < 0 && req_q[j].addr == 32'h1000_0004) n = j;
    chk("pf next word requested", {31'd0, n >= 0}, 32'd1);
    if (n >= 0) chk("pf request before 3rd read", {31'd0, req_q[n].falls < 3}, 32'd1);
    i_bank_prefetch = 1'b0;
    cycles(10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/n64_pi_responder.md
Name: n64_pi_responder

Overview:
- N64-facing end of the PI cartridge bus.
- Samples asynchronous PI strobes and multiplexed AD[15:0], assembles the 32-bit bus address, and presents it to the bank decoder.
- Converts N64 half-word read/write cycles into 32-bit word requests to the selected bank, and drives read data back onto AD.
- Sits between the N64 pins and the bank decoder plus the bank arbitration.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on all N64 inputs (minimum 2).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_n64_pi_aleh  in  1  address latch enable high, async
- i_n64_pi_alel  in  1  address latch enable low, async
- i_n64_pi_read  in  1  read strobe, active-low, async
- i_n64_pi_write  in  1  write strobe, active-low, async
- i_n64_pi_ad  in  16  AD bus input
- o_n64_pi_ad  out  16  AD bus drive value
- o_n64_pi_ad_oe  out  1  AD output enable
- o_address  out  32  current word address (bits [1:0] = 0), to the bank decoder
- i_bank  in  4  decoded bank for o_address
- i_bank_prefetch  in  1  bank allows read-ahead
- o_request  out  1  bank request, held until i_ack
- o_write  out  1  request direction (1 = write)
- o_data  out  32  write data
- i_ack  in  1  request completed; i_data valid on reads
- i_data  in  32  read data

Behaviour:
- Reset values:
  - o_n64_pi_ad = 0, o_n64_pi_ad_oe = 0.
  - o_address = 0, o_request = 0, o_write = 0, o_data = 0.
  - State IDLE; buffers invalid.
- Input synchronisation:
  - All N64 inputs pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized strobes.
  - AD is captured from the synchronized copy on the cycle the edge is detected.
- Address phase:
  - Rising ALEH aborts any transaction (see below) and enters ADDR.
  - ALEH falling latches address[31:16].
  - ALEL falling latches address[15:0] and enters IDLE-READY.
  - AD[0] is ignored (forced 0).
  - The half-word pointer is address[1].
- States: IDLE, ADDR, FETCH, READY, WCOLLECT, WISSUE.
- Read, READ falling:
  - If the word buffer is valid for the current address: drive the selected half next cycle.
    - address[1]=0 selects data[31:16]; address[1]=1 selects data[15:0].
    - Assert oe.
  - Otherwise enter FETCH: o_request=1, o_write=0 until i_ack.
    - On i_ack, store i_data and drive the half in the same cycle as the store.
    - Return to READY.
- Read, READ rising:
  - Deassert oe; address += 2.
  - Crossing into a new word invalidates the buffer unless the prefetch slot holds it.
- Write:
  - WRITE falling is ignored.
  - WRITE rising captures AD:
    - address[1]=0 writes o_data[31:16].
    - address[1]=1 writes o_data[15:0] and moves to WISSUE: o_request=1, o_write=1, held until i_ack.
  - address += 2 after each half.
  - WRITE rising while in WISSUE stalls capture until the ack, then completes in order; at most one half is buffered.
- Invalid bank (i_bank == BANK_INVALID):
  - No request is issued.
  - Reads drive 16'h0000.
  - Writes are discarded.
- Address arithmetic: 32-bit, wraps 0xFFFF_FFFE -> 0x0000_0000 with no special casing.
- Abort (ALEH rising mid-transaction):
  - Buffers are invalidated; oe = 0.
  - An outstanding o_request stays high until i_ack, and its data is discarded.
  - A new request is issued only after that ack.
- i_reset mid-request drops o_request in the next cycle; the bank side must tolerate this.
- READ and WRITE low at the same time is a protocol error; READ takes priority.

Optional Feature:
- Macro N64_PI_PREFETCH_EN.
- Defined:
  - When a word arrives and i_bank_prefetch = 1, a request for address+4 is issued immediately into a second word slot.
  - On word crossing, the prefetch slot becomes current and the next prefetch is issued.
- Undefined:
  - Single buffer; every new word costs a FETCH on the first READ falling edge.
  - i_bank_prefetch is ignored.

Decomposition:
- Shared constants.vh:
  - BANK_* codes.
  - State encodings N64_PI_STATE_*.
- Sub-module n64_pi_sync holds the SYNC_STAGES synchronizer plus rise/fall edge outputs per strobe.
  - It is instantiated for the 4 strobes.
  - The AD bus uses a plain synchronizer.

Test Plan:
- ROM read, no prefetch:
  - Stimulus: address 0x1000_0040, 4 READ pulses; bank ROM returns 0x11223344 then 0x55667788.
  - Required: AD = 0x1122, 0x3344, 0x5566, 0x7788; exactly 2 requests, at 0x1000_0040 and 0x1000_0044.
- SRAM write:
  - Stimulus: address 0x0800_0000; WRITE halves 0xAAAA, 0xBBBB.
  - Required: one write request, o_data = 0xAAAABBBB at o_address = 0x0800_0000.
- Invalid bank:
  - Stimulus: address 0x0500_0000, 2 READ pulses.
  - Required: AD = 0x0000 both times; o_request never asserted.
- Abort:
  - Stimulus: ALEH rising while FETCH is awaiting ack, then a new address 0x1000_0100.
  - Required: no new request until the old i_ack; stale data never driven; next request at 0x1000_0100.
- Prefetch (N64_PI_PREFETCH_EN, i_bank_prefetch = 1):
  - Stimulus: 8 READ pulses from 0x1000_0000.
  - Required: request for 0x1000_0004 is issued before the 3rd READ falling edge; no FETCH stall after the first word.
- Reset:
  - Stimulus: i_reset during WISSUE.
  - Required: next cycle o_request = 0, oe = 0, all outputs at reset values.
